// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM state encoding for alu_exec and the ALU control unit.
package alu_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] LW   = 4'b0010;
  localparam logic [CTRL_W-1:0] SW   = 4'b0011;
  localparam logic [CTRL_W-1:0] SLL  = 4'b0100;
  localparam logic [CTRL_W-1:0] AND  = 4'b0101;
  localparam logic [CTRL_W-1:0] ANDI = 4'b0110;
  localparam logic [CTRL_W-1:0] NOR  = 4'b0111;
  localparam logic [CTRL_W-1:0] BEQ  = 4'b1000;
  localparam logic [CTRL_W-1:0] JAL  = 4'b1001;
  localparam logic [CTRL_W-1:0] JR   = 4'b1010;
  localparam logic [CTRL_W-1:0] SLT  = 4'b1011;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] HOLD  = 2'd2;

  // 0001 and 1100..1111 are unassigned codes
  function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
    return !((c == 4'b0001) || (c >= 4'b1100));
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative left shifter: load operand and count, shift one bit per cycle until the count hits 0.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] amount,
  output logic               done_c,
  output logic [WIDTH-1:0]   shifted_c
);

  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= value;
      count_q <= amount;
    end else if (count_q != '0) begin
      data_q  <= data_q << 1;
      count_q <= count_q - SHAMT_W'(1);
    end
  end

  // Final step: the shift performed on the edge where the count reaches 0
  assign done_c    = (count_q == SHAMT_W'(1));
  assign shifted_c = data_q << 1;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshake on input and output.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel sll; otherwise sll shifts one bit per cycle.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               ready_q, valid_q;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   res_c;
  logic               illegal_c;
  logic               iter_c;
  logic               done_c;
  logic [WIDTH-1:0]   shifted_c;

  // Single-cycle operation result from the offered operands
  always_comb begin
    res_c = '0;
    case (alu_ctrl)
      ADD, LW, SW: res_c = op_a + op_b;
`ifdef ALU_FAST_SHIFT_EN
      SLL:         res_c = op_b << shamt;
`else
      SLL:         res_c = op_b;
`endif
      AND, ANDI:   res_c = op_a & op_b;
      NOR:         res_c = ~(op_a | op_b);
      BEQ:         res_c = op_a - op_b;
      JAL:         res_c = op_a + WIDTH'(4);
      JR:          res_c = op_a;
      SLT:         res_c = WIDTH'($signed(op_a) < $signed(op_b));
      default:     res_c = '0;
    endcase
  end

  assign illegal_c = !ctrl_legal(alu_ctrl);

`ifdef ALU_FAST_SHIFT_EN
  assign iter_c    = 1'b0;
  assign done_c    = 1'b0;
  assign shifted_c = '0;
`else
  logic load_c;

  assign iter_c = (alu_ctrl == SLL) && (shamt != '0);
  assign load_c = ready_q && in_valid && iter_c;

  alu_shift_seq #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .value     (op_b),
    .amount    (shamt),
    .done_c    (done_c),
    .shifted_c (shifted_c)
  );
`endif

  // Next state and next output registers
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (iter_c) begin
            state_d = SHIFT;
          end else begin
            state_d   = HOLD;
            result_d  = res_c;
            illegal_d = illegal_c;
            zero_d    = !illegal_c && (res_c == '0);
          end
        end
      end
      SHIFT: begin
        if (done_c) begin
          state_d   = HOLD;
          result_d  = shifted_c;
          illegal_d = 1'b0;
          zero_d    = (shifted_c == '0);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      valid_q   <= (state_d == HOLD);
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomised checks of alu_exec against a scoreboard of expected results.
module tb_alu_exec;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] s);
    exp_t e;
    e.il = 1'b0;
    case (c)
      4'd0, 4'd2, 4'd3: e.r = a + b;
      4'd4:             e.r = b << s;
      4'd5, 4'd6:       e.r = a & b;
      4'd7:             e.r = ~(a | b);
      4'd8:             e.r = a - b;
      4'd9:             e.r = a + 32'd4;
      4'd10:            e.r = a;
      4'd11:            e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.r  = 32'd0;
        e.il = 1'b1;
      end
    endcase
    e.z = !e.il && (e.r == 32'd0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [4:0] s);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (c == 4'd4) ? 1 + int'(s) : 1;
`endif
  endfunction

  // Offer one op at the negedge; returns once the accept edge has passed
  task automatic offer(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    @(negedge clk);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    shamt    = s;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back(model(c, a, b, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, check latency and scoreboard head
  task automatic collect(input string tag, input int lat);
    int   n = 1;
    logic rdy_seen = 1'b0;
    exp_t e;
    while (!out_valid && n < 64) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".ready_low"}, 32'(rdy_seen | in_ready), 32'd0);
    e = sb.pop_front();
    chk({tag, ".result"}, result, e.r);
    chk({tag, ".zero"}, 32'(zero), 32'(e.z));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.il));
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s);
    out_ready = 1'b1;
    offer(tag, c, a, b, s);
    collect(tag, exp_lat(c, s));
    @(posedge clk);
    #1;
    chk({tag, ".drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen;
    logic [3:0]  rc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_ctrl = '0;
    op_a = '0;
    op_b = '0;
    shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.zero", 32'(zero), 32'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    run_op("add", 4'd0, 32'd5, 32'd7, 5'd0);
    run_op("beq", 4'd8, 32'h1234, 32'h1234, 5'd0);
    run_op("slt", 4'd11, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op("slt_neg", 4'd11, 32'd1, 32'hFFFF_FFFF, 5'd0);
    run_op("sll4", 4'd4, 32'd0, 32'd1, 5'd4);
    run_op("sll0", 4'd4, 32'd0, 32'hA5, 5'd0);
    run_op("sll31", 4'd4, 32'd0, 32'h3, 5'd31);
    run_op("jal", 4'd9, 32'hFFFF_FFFE, 32'd0, 5'd0);
    run_op("jr", 4'd10, 32'hDEAD_BEEF, 32'd1, 5'd0);
    run_op("andi", 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    run_op("ill1101", 4'd13, 32'd3, 32'd3, 5'd0);
    run_op("ill0001", 4'd1, 32'd0, 32'd0, 5'd0);

    // Output back-pressure: result stable, new offers ignored
    out_ready = 1'b0;
    offer("nor", 4'd7, 32'd0, 32'd0, 5'd0);
    collect("nor", 1);
    held = result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_ctrl = 4'd0;
      op_a = 32'd1;
      op_b = 32'd1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.result", result, held);
      chk("stall.zero", 32'(zero), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall.drop", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("stall.no_ghost", 32'(seen), 32'd0);

    for (int i = 0; i < 10; i++) begin
      rc = 4'($urandom_range(0, 15));
      run_op("rand", rc, $urandom, $urandom, 5'($urandom_range(0, 6)));
    end

    // Reset in the middle of a long shift discards it
    out_ready = 1'b1;
    offer("rst_shift", 4'd4, 32'd0, 32'd1, 5'd20);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_shift.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_shift.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("rst_shift.no_valid", 32'(seen), 32'd0);

    run_op("after_rst", 4'd5, 32'hFF00, 32'h0FF0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 The block SHALL have port alu_ctrl, input, 4 bits: the operation code from the ALU control unit.
REQ-007 The block SHALL have ports op_a and op_b, input, WIDTH bits each: the operands (rs-derived and rt/immediate-derived).
REQ-008 The block SHALL have port shamt, input, 5 bits: the shift amount for sll.
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), result (output, WIDTH), zero (output, 1) and illegal (output, 1).

Function
REQ-010 Accept SHALL occur on a rising edge where in_valid && in_ready; alu_ctrl, op_a, op_b and shamt are captured on that edge.
REQ-011 in_ready SHALL equal (state == IDLE); in_valid while not IDLE is ignored and has no effect.
REQ-012 The states SHALL be IDLE, SHIFT and HOLD; IDLE->HOLD on accept of a single-cycle op; IDLE->SHIFT on accept of sll with shamt != 0; SHIFT->HOLD when the shift count reaches 0; HOLD->IDLE on out_valid && out_ready.
REQ-013 Codes SHALL compute: 0000, 0010, 0011 = op_a+op_b; 0100 = op_b<<shamt; 0101, 0110 = op_a&op_b; 0111 = ~(op_a|op_b); 1000 = op_a-op_b; 1001 = op_a+4; 1010 = op_a; 1011 = 1 if signed op_a < signed op_b, else 0.
REQ-014 All add/sub arithmetic SHALL be modulo 2^WIDTH, carry and overflow discarded.
REQ-015 Codes 0001 and 1100-1111 SHALL produce result 0, illegal 1 and zero 0; all legal codes SHALL produce illegal 0 and zero = (result == 0).
REQ-016 Single-cycle ops, and sll with shamt 0, SHALL register result on the accept edge, so out_valid is high in the following cycle.
REQ-017 sll with shamt k >= 1 SHALL shift one bit per cycle in SHIFT, so out_valid rises k cycles after the single-cycle timing.
REQ-018 out_valid SHALL equal (state == HOLD); result, zero and illegal SHALL remain stable while out_valid && !out_ready.
REQ-019 Maximum throughput SHALL be one operation per two cycles; in_ready rises the cycle after the output transfer.

Reset
REQ-020 With rst high at a clock edge, state SHALL go to IDLE and out_valid, result, zero, illegal and the shift counter SHALL go to 0.
REQ-021 Reset in SHIFT or HOLD SHALL discard the pending operation without ever asserting out_valid for it.
REQ-022 in_ready SHALL be 1 in the cycle after reset is released; rst takes priority over a simultaneous accept or output transfer.

Configuration
REQ-023 Macro ALU_FAST_SHIFT_EN defined: sll SHALL use a combinational barrel shift, complete in single-cycle timing, and SHIFT is never entered.
REQ-024 Macro ALU_FAST_SHIFT_EN undefined: sll SHALL use the iterative timing of REQ-017. Results SHALL be identical in both builds.

Structure
REQ-025 A shared package alu_pkg SHALL hold the 4-bit alu_ctrl code constants (ADD, LW, SW, SLL, AND, ANDI, NOR, BEQ, JAL, JR, SLT) and the state encoding; the ALU control unit SHALL use the same constants.
REQ-026 The iterative shifter (load, count-down, done) SHALL be a sub-module alu_shift_seq, instantiated only when ALU_FAST_SHIFT_EN is undefined.

Verification
REQ-027 Reset, then accept add op_a=5, op_b=7 with out_ready=1: result=12, zero=0, out_valid high exactly one cycle later.
REQ-028 beq op_a=op_b=0x1234: result=0, zero=1; slt op_a=0xFFFFFFFF, op_b=1: result=1.
REQ-029 sll op_b=1, shamt=4 in the iterative build: result=0x10, out_valid 5 cycles after accept, in_ready low throughout; in the fast build: 1 cycle.
REQ-030 Hold out_ready=0 for 3 cycles after nor op_a=op_b=0: result=0xFFFFFFFF stays stable and in_ready stays 0; a new in_valid during this time is not accepted.
REQ-031 alu_ctrl=1101: illegal=1, result=0, zero=0; rst asserted mid-SHIFT (shamt=20): out_valid never rises and in_ready=1 after release.
